// File: rtl/axi_mem_slave.sv
// AXI3 subordinate backed by a 256-bit wide byte-enabled memory array.
// One read and one write burst can be in flight, and they run independently.
module axi_mem_slave #(
  parameter int MEM_BYTES = 65536,
  parameter int ID_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] awid_i,
  input  logic [31:0]     awaddr_i,
  input  logic [7:0]      awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic [1:0]      awburst_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [ID_W-1:0] wid_i,
  input  logic [255:0]    wdata_i,
  input  logic [31:0]     wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [ID_W-1:0] bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [31:0]     araddr_i,
  input  logic [7:0]      arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic [1:0]      arburst_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  output logic [ID_W-1:0] rid_o,
  output logic [255:0]    rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = AW - 5;
  localparam int WORDS = MEM_BYTES / 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // Burst legality; the end address is formed in 33 bits so a wrap past 4 GB still decodes as out of range.
  function automatic logic [1:0] f_burst_resp(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] v_end;
    v_end = {1'b0, addr} + (({25'd0, len} + 33'd1) << 5);
    if (v_end > 33'(MEM_BYTES)) return RESP_DECERR;
    else if (size != 3'b101 || burst != 2'b01) return RESP_SLVERR;
    else return RESP_OKAY;
  endfunction

  logic [255:0]    r_mem [WORDS];

  rstate_t         r_rstate;
  logic            r_arready, r_rvalid, r_rlast;
  logic [255:0]    r_rdata;
  logic [1:0]      r_rresp;
  logic [ID_W-1:0] r_rid;
  logic [IW-1:0]   r_ridx;
  logic [7:0]      r_rlen, r_rbeat;

  wstate_t         r_wstate;
  logic            r_awready, r_wready, r_bvalid;
  logic [1:0]      r_wresp, r_bresp;
  logic [ID_W-1:0] r_wid, r_bid;
  logic [IW-1:0]   r_widx;
  logic [7:0]      r_wlen, r_wbeat;

  logic            w_ar_hs, w_aw_hs, w_w_hs, w_mem_we;
  logic [1:0]      w_ar_resp, w_aw_resp, w_wresp_nxt;
  logic [IW-1:0]   w_ridx_nxt;

  assign w_ar_hs     = arvalid_i & r_arready;
  assign w_aw_hs     = awvalid_i & r_awready;
  assign w_w_hs      = wvalid_i & r_wready;
  assign w_ar_resp   = f_burst_resp(araddr_i, arlen_i, arsize_i, arburst_i);
  assign w_aw_resp   = f_burst_resp(awaddr_i, awlen_i, awsize_i, awburst_i);
  assign w_ridx_nxt  = r_ridx + IW'(1);
  // A protocol slip on a beat only downgrades an OKAY burst; earlier errors are kept.
  assign w_wresp_nxt = (r_wresp == RESP_OKAY &&
                        (wlast_i != (r_wbeat == r_wlen) || wid_i != r_wid)) ? RESP_SLVERR : r_wresp;
  assign w_mem_we    = !rst && (r_wstate == W_DATA) && w_w_hs && (r_wresp == RESP_OKAY);

  // Array write port; no reset so contents persist across rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 32; b++) begin
        if (wstrb_i[b]) r_mem[r_widx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read channel FSM with a registered data beat that holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_ridx    <= '0;
      r_rlen    <= 8'd0;
      r_rbeat   <= 8'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rid     <= arid_i;
            r_ridx    <= araddr_i[AW-1:5];
            r_rlen    <= arlen_i;
            r_rbeat   <= 8'd0;
            r_rresp   <= w_ar_resp;
            r_rdata   <= (w_ar_resp == RESP_OKAY) ? r_mem[araddr_i[AW-1:5]] : '0;
            r_rlast   <= (arlen_i == 8'd0);
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_rvalid && rready_i) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rbeat <= r_rbeat + 8'd1;
              r_ridx  <= w_ridx_nxt;
              r_rdata <= (r_rresp == RESP_OKAY) ? r_mem[w_ridx_nxt] : '0;
              r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM; the beat count, not wlast, decides when the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_wresp   <= RESP_OKAY;
      r_wid     <= '0;
      r_widx    <= '0;
      r_wlen    <= 8'd0;
      r_wbeat   <= 8'd0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wid     <= awid_i;
            r_widx    <= awaddr_i[AW-1:5];
            r_wlen    <= awlen_i;
            r_wbeat   <= 8'd0;
            r_wresp   <= w_aw_resp;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx  <= r_widx + IW'(1);
            r_wbeat <= r_wbeat + 8'd1;
            r_wresp <= w_wresp_nxt;
            if (r_wbeat == r_wlen) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              r_bresp  <= w_wresp_nxt;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign arready_o = r_arready;
  assign rvalid_o  = r_rvalid;
  assign rlast_o   = r_rlast;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign rid_o     = r_rid;
  assign awready_o = r_awready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bresp_o   = r_bresp;
  assign bid_o     = r_bid;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, backpressure, errors,
// concurrent channels and reset in the middle of a write burst.
module tb_axi_mem_slave;
  localparam int MEM_BYTES = 65536;
  localparam int ID_W      = 4;
  localparam logic [31:0] ALL_STRB = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [ID_W-1:0] awid_i, wid_i, arid_i, bid_o, rid_o;
  logic [31:0] awaddr_i, araddr_i, wstrb_i;
  logic [7:0] awlen_i, arlen_i;
  logic [2:0] awsize_i, arsize_i;
  logic [1:0] awburst_i, arburst_i, bresp_o, rresp_o;
  logic awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic [255:0] wdata_i, rdata_o;

  axi_mem_slave #(.MEM_BYTES(MEM_BYTES), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] rd_data [256];
  logic [1:0]   rd_resp [256];
  int rd_n, rd_bad;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int t = 0;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = 3'd5; arburst_i = 2'b01; arvalid_i = 1'b1;
    while (!arready_o && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("ar_timeout", 256'd0, 256'd1);
    @(negedge clk);
    arvalid_i = 1'b0;
  endtask

  task automatic r_collect(input logic [ID_W-1:0] id, input int len, input bit toggle);
    int cyc = 0;
    bit stalled = 1'b0, done = 1'b0;
    logic [255:0] hd;
    logic hl;
    logic [ID_W-1:0] hid;
    rd_n = 0; rd_bad = 0;
    while (!done && cyc < 2000) begin
      rready_i = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled && (rdata_o !== hd || rlast_o !== hl || rid_o !== hid)) rd_bad++;
      if (rvalid_o && rready_i) begin
        if (rd_n < 256) begin rd_data[rd_n] = rdata_o; rd_resp[rd_n] = rresp_o; end
        if (rid_o !== id || rlast_o !== (rd_n == len)) rd_bad++;
        rd_n++;
        stalled = 1'b0;
        done = rlast_o;
      end else if (rvalid_o) begin
        stalled = 1'b1; hd = rdata_o; hl = rlast_o; hid = rid_o;
      end
      @(negedge clk);
      cyc++;
    end
    rready_i = 1'b0;
    if (!done) check("r_timeout", 256'd0, 256'd1);
  endtask

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int t = 0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = 3'd5; awburst_i = burst; awvalid_i = 1'b1;
    while (!awready_o && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("aw_timeout", 256'd0, 256'd1);
    @(negedge clk);
    awvalid_i = 1'b0;
  endtask

  // Beat k carries pat(base + k*step); early >= 0 moves wlast onto that beat.
  task automatic w_send(input logic [ID_W-1:0] id, input int n, input logic [7:0] base,
                        input logic [7:0] step, input logic [31:0] strb, input int early);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      wid_i = id; wdata_i = pat(base + 8'(k) * step); wstrb_i = strb; wvalid_i = 1'b1;
      wlast_i = (early >= 0) ? (k == early) : (k == n - 1);
      while (!wready_o && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("w_timeout", 256'd0, 256'd1);
      @(negedge clk);
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [ID_W-1:0] id);
    int t = 0;
    bready_i = 1'b1;
    while (!bvalid_o && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("b_timeout", 256'd0, 256'd1);
    resp = bresp_o; id = bid_o;
    @(negedge clk);
    bready_i = 1'b0;
  endtask

  task automatic wr(input logic [ID_W-1:0] id, input logic [31:0] addr, input int n, input logic [7:0] base,
                    input logic [7:0] step, input logic [31:0] strb, input logic [1:0] burst,
                    output logic [1:0] resp);
    logic [ID_W-1:0] bid;
    aw_send(id, addr, 8'(n - 1), burst);
    w_send(id, n, base, step, strb, -1);
    b_recv(resp, bid);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic [ID_W-1:0] bid;
    int e, held, acc;
    rst = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {awready_o, arready_o, wready_o}, 3'b110);
    check("rst_valid", {bvalid_o, rvalid_o, rlast_o}, 3'b000);
    check("rst_rdata", rdata_o, 256'd0);
    check("rst_resp_id", {rresp_o, bresp_o, rid_o, bid_o}, 12'd0);

    // Write-then-read, 4 beats at 0x100
    aw_send(4'd5, 32'h100, 8'd3, 2'b01);
    w_send(4'd5, 4, 8'h00, 8'h11, ALL_STRB, -1);
    b_recv(resp, bid);
    check("t1_bresp", resp, 2'b00);
    check("t1_bid", bid, 4'd5);
    ar_send(4'd6, 32'h100, 8'd3);
    check("t1_rvalid_lat", rvalid_o, 1'b1);
    r_collect(4'd6, 3, 1'b0);
    check("t1_beats", rd_n, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t1_data%0d", k), rd_data[k], pat(8'(k * 17)));
    check("t1_rresp", rd_resp[3], 2'b00);
    check("t1_rlast_rid", rd_bad, 0);
    check("t1_r_idle", {rvalid_o, arready_o}, 2'b01);

    // Strobes: only bytes 0-3 cleared
    wr(4'd1, 32'h0, 1, 8'hFF, 8'h00, ALL_STRB, 2'b01, resp);
    wr(4'd1, 32'h0, 1, 8'h00, 8'h00, 32'h0000_000F, 2'b01, resp);
    ar_send(4'd1, 32'h0, 8'd0);
    r_collect(4'd1, 0, 1'b0);
    check("t2_strobe", rd_data[0], {{28{8'hFF}}, 32'h0});

    // Backpressure: 128 distinct beats read with rready toggling
    wr(4'd2, 32'h2000, 128, 8'h00, 8'h01, ALL_STRB, 2'b01, resp);
    check("t3_wr_bresp", resp, 2'b00);
    ar_send(4'd3, 32'h2000, 8'd127);
    r_collect(4'd3, 127, 1'b1);
    check("t3_beats", rd_n, 128);
    e = 0;
    for (int k = 0; k < 128; k++) if (rd_data[k] !== pat(8'(k))) e++;
    check("t3_data", e, 0);
    check("t3_stable", rd_bad, 0);

    // DECERR read past the end of the array
    ar_send(4'd2, 32'(MEM_BYTES - 32), 8'd1);
    r_collect(4'd2, 1, 1'b0);
    check("t4a_beats", rd_n, 2);
    check("t4a_resp", {rd_resp[0], rd_resp[1]}, 4'b1111);
    check("t4a_data", rd_data[0] | rd_data[1], 256'd0);

    // SLVERR on WRAP burst leaves the array unchanged
    wr(4'd3, 32'h300, 1, 8'h5A, 8'h00, ALL_STRB, 2'b01, resp);
    wr(4'd3, 32'h300, 1, 8'hA5, 8'h00, ALL_STRB, 2'b10, resp);
    check("t4b_bresp", resp, 2'b10);
    ar_send(4'd3, 32'h300, 8'd0);
    r_collect(4'd3, 0, 1'b0);
    check("t4b_unchanged", rd_data[0], pat(8'h5A));

    // Early wlast: still four beats, then SLVERR
    aw_send(4'd4, 32'h400, 8'd3, 2'b01);
    w_send(4'd4, 4, 8'h40, 8'h01, ALL_STRB, 1);
    check("t4c_wdone", {wready_o, bvalid_o}, 2'b01);
    b_recv(resp, bid);
    check("t4c_bresp", resp, 2'b10);

    // Concurrent read and write, B stalled for 10 cycles
    arid_i = 4'd7; araddr_i = 32'h0; arlen_i = 8'd0; arsize_i = 3'd5; arburst_i = 2'b01; arvalid_i = 1'b1;
    awid_i = 4'd9; awaddr_i = 32'h1000; awlen_i = 8'd1; awsize_i = 3'd5; awburst_i = 2'b01; awvalid_i = 1'b1;
    check("t5_rdy", {arready_o, awready_o}, 2'b11);
    @(negedge clk);
    arvalid_i = 1'b0; awvalid_i = 1'b0;
    fork
      r_collect(4'd7, 0, 1'b0);
      w_send(4'd9, 2, 8'h30, 8'h01, ALL_STRB, -1);
    join
    check("t5_rdata", rd_data[0], {{28{8'hFF}}, 32'h0});
    held = 0; acc = 0;
    awid_i = 4'd1; awaddr_i = 32'h1800; awlen_i = 8'd0; awburst_i = 2'b01; awvalid_i = 1'b1;
    repeat (10) begin
      if (bvalid_o) held++;
      if (awready_o) acc++;
      @(negedge clk);
    end
    check("t5_bheld", held, 10);
    check("t5_aw_blocked", acc, 0);
    check("t5_bid", {bid_o, bresp_o}, {4'd9, 2'b00});
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    check("t5_aw_after_b", awready_o, 1'b1);
    @(negedge clk);
    awvalid_i = 1'b0;
    w_send(4'd1, 1, 8'h77, 8'h00, ALL_STRB, -1);
    b_recv(resp, bid);
    check("t5_second_b", {bid, resp}, {4'd1, 2'b00});
    ar_send(4'd7, 32'h1000, 8'd1);
    r_collect(4'd7, 1, 1'b0);
    check("t5_wdata", {rd_data[0] == pat(8'h30), rd_data[1] == pat(8'h31)}, 2'b11);

    // Reset on beat 2 of an 8-beat write
    wr(4'd2, 32'h3000, 8, 8'h80, 8'h01, ALL_STRB, 2'b01, resp);
    aw_send(4'd4, 32'h3000, 8'd7, 2'b01);
    for (int k = 0; k < 3; k++) begin
      int t = 0;
      wid_i = 4'd4; wdata_i = pat(8'(8'hC0 + k)); wstrb_i = ALL_STRB; wlast_i = 1'b0; wvalid_i = 1'b1;
      while (!wready_o && t < 200) begin @(negedge clk); t++; end
      if (k == 2) rst = 1'b1;
      @(negedge clk);
    end
    check("t6_after_rst", {rvalid_o, bvalid_o, wready_o, awready_o, arready_o}, 5'b00011);
    rst = 1'b0; wvalid_i = 1'b0;
    ar_send(4'd5, 32'h3000, 8'd7);
    r_collect(4'd5, 7, 1'b0);
    check("t6_beats", rd_n, 8);
    e = 0;
    for (int k = 0; k < 8; k++) if (rd_data[k] !== ((k < 2) ? pat(8'(8'hC0 + k)) : pat(8'(8'h80 + k)))) e++;
    check("t6_array", e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Behavioural AXI3 subordinate backed by an internal byte-enabled memory array; the responder end of the DMA engine's 256-bit AXI master port.
- Serves AR/R and AW/W/B bursts independently, with one outstanding read and one outstanding write.
- Used as the target memory in block and system benches, and as a simple scratchpad in FPGA builds.

Parameters:
- MEM_BYTES, 65536: array size in bytes; power of two, at least 32.
- ID_W, 4: AXI ID width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- awid_i  in  ID_W  write ID
- awaddr_i  in  32  write byte address
- awlen_i  in  8  beats-1
- awsize_i  in  3  beat size
- awburst_i  in  2  burst type
- awvalid_i  in  1  AW valid
- awready_o  out  1  AW ready
- wid_i  in  ID_W  write data ID
- wdata_i  in  256  write data
- wstrb_i  in  32  byte enables
- wlast_i  in  1  last write beat
- wvalid_i  in  1  W valid
- wready_o  out  1  W ready
- bid_o  out  ID_W  response ID
- bresp_o  out  2  write response
- bvalid_o  out  1  B valid
- bready_i  in  1  B ready
- arid_i  in  ID_W  read ID
- araddr_i  in  32  read byte address
- arlen_i  in  8  beats-1
- arsize_i  in  3  beat size
- arburst_i  in  2  burst type
- arvalid_i  in  1  AR valid
- arready_o  out  1  AR ready
- rid_o  out  ID_W  read ID
- rdata_o  out  256  read data
- rresp_o  out  2  read response
- rlast_o  out  1  last read beat
- rvalid_o  out  1  R valid
- rready_i  in  1  R ready

Behaviour:
- Reset: both FSMs go to IDLE. All valids, rlast_o and beat counters are 0. rdata_o, rresp_o, bresp_o, rid_o and bid_o are 0. awready_o and arready_o are 1. wready_o is 0.
- Memory array is never reset; contents survive rst.
- Addressing: word index = addr[log2(MEM_BYTES)-1:5]. addr[4:0] is ignored, so transfers are always 32-byte aligned. Each beat adds 1 to the index. 4KB crossing is not checked.
- Burst check at acceptance, with priority DECERR(2'b11) > SLVERR(2'b10) > OKAY(2'b00):
  - DECERR: addr + (len+1)*32 > MEM_BYTES, evaluated in 33-bit arithmetic.
  - SLVERR: size != 3'b101, or burst != 2'b01 (INCR).
  - An erroring burst still runs the full len+1 beats. It makes no array access, and reads return rdata 0.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready_o=1. On arvalid_i&arready_o, capture id, index, len and resp, and go to R_DATA.
  - R_DATA: rvalid_o=1 from the cycle after AR handshake. rdata_o is registered, holding the current beat's data.
  - rdata_o, rresp_o, rid_o and rlast_o stay stable while rvalid_o&!rready_i.
  - On each rvalid_o&rready_i, advance the beat; the next beat appears the following cycle, so streaming is back-to-back with no bubble. rlast_o=1 when beat==len.
  - On the last handshake, go to R_IDLE: rvalid_o=0 and arready_o=1 next cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready_o=1. On handshake, capture id, index, len and resp, then go to W_DATA.
  - W_DATA: wready_o=1. On each wvalid_i&wready_o with resp OKAY, write the bytes whose wstrb_i bits are set, then increment the beat.
  - Completion is set by the beat count (len+1), not by wlast_i.
  - Any beat where wlast_i != (beat==len), or wid_i != captured id, upgrades resp to SLVERR if it is OKAY. Data already written stays written.
  - W_RESP: bvalid_o=1 from the cycle after the final W beat, with bid_o = captured id and bresp_o = resp. Hold until bready_i, then return to W_IDLE; awready_o=1 next cycle.
- Read and write proceed concurrently.
- Same-word write and read in the same cycle: the read returns the old data (read-before-write). The new data is visible on the next beat or next burst.
- rst mid-burst: FSMs return to IDLE immediately with all valids low. Beats already written persist, and no B or remaining R beats are issued.

Test Plan:
- Write-then-read: AW addr 0x100, len 3, INCR, size 5, 4 beats with data k*0x11 repeated, wstrb all 1s. Then AR same. -> B OKAY with bid=awid; R returns 4 matching beats, rlast on beat 3, rvalid first high the cycle after AR handshake.
- Strobes: preload word 0x0 with 0xFF..FF; write 0 with wstrb=0x0000_000F. -> readback has bytes 0-3 = 0 and bytes 4-31 = 0xFF.
- Backpressure: 128-beat read with rready toggling 1/0 every cycle. -> rdata, rlast and rid stay stable while stalled; exactly 128 handshakes; no beat skipped or repeated.
- Errors:
  - AR addr MEM_BYTES-32, len 1 -> 2 beats DECERR, rdata 0.
  - AW burst=2'b10 -> SLVERR and array unchanged.
  - Early wlast on beat 1 of a 4-beat burst -> still 4 beats accepted, bresp SLVERR.
- Concurrency: read burst to 0x0 and write burst to 0x1000 issued in the same cycle, bready held 0 for 10 cycles. -> both complete; bvalid held 10 cycles; a second AW is not accepted until B handshake.
- Reset mid-burst: assert rst on beat 2 of an 8-beat write. -> next cycle all valids 0, awready/arready 1; beats 0-1 in the array, beats 2-7 untouched.
